// File: rtl/ram8_pkg.sv
// rtl/ram8_pkg.sv - shared sizing constants for the 8-word register RAM
package ram8_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEPTH         = 8;
    localparam int ADDR_W        = 3;

endpackage

// File: rtl/word_reg.sv
// rtl/word_reg.sv - one memory word: W-bit register with load enable
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears q to 0
//   load    : capture d on the next rising edge
//   d / q   : data in / stored word
module word_reg #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram8_port.sv
// rtl/ram8_port.sv - 8-word register RAM, free write port, ready/valid read port
//   clock, reset_n               : clock and asynchronous active-low reset
//   write_en/write_addr/write_data : write port, never stalled
//   req_valid/req_addr/req_ready : read request handshake
//   rsp_valid/rsp_data/rsp_ready : registered read response, one-entry stage
module ram8_port
    import ram8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = ram8_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    input  logic              rsp_ready
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             accept;
    logic             fwd;
    logic [WIDTH-1:0] rd_word;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        word_reg #(
            .W (WIDTH)
        ) u_word (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (write_en && (write_addr == ADDR_W'(i))),
            .d       (write_data),
            .q       (mem_q[i])
        );
    end

    // The response slot frees up in the same cycle the consumer takes it.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // A write landing on the requested word at the accepting edge wins, so the
    // response reflects the memory state after that edge.
    assign fwd     = write_en && (write_addr == req_addr);
    assign rd_word = fwd ? write_data : mem_q[req_addr];

    // rsp_data is only loaded on accept, so it holds through backpressure and
    // keeps its last value once the response is consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_word;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram8_port.sv
// tb/tb_ram8_port.sv - directed self-checking bench for ram8_port
module tb_ram8_port;

    logic        clock;
    logic        reset_n;
    logic        write_en;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        req_valid;
    logic [2:0]  req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_ready;

    int tests;
    int fails;

    ram8_port dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset_n    = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b1;

        // reset state
        #3;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'h0000);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        #4 reset_n = 1'b1;
        tick();

        // write BEEF to addr 2, read it, then reset while the response is held
        wr(3'd2, 16'hBEEF);
        req_valid = 1'b1; req_addr = 3'd2;
        tick();
        req_valid = 1'b0;
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        check("pre_reset_data",  32'(rsp_data),  32'hBEEF);
        rsp_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(rsp_valid), 32'd0);
        check("async_reset_data",  32'(rsp_data),  32'h0000);
        #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b1; req_addr = 3'd2;
        tick();
        req_valid = 1'b0;
        check("post_reset_addr2_valid", 32'(rsp_valid), 32'd1);
        check("post_reset_addr2_data",  32'(rsp_data),  32'h0000);
        tick();

        // basic read
        wr(3'd5, 16'h1234);
        req_valid = 1'b1; req_addr = 3'd5;
        tick();
        req_valid = 1'b0;
        check("basic_valid", 32'(rsp_valid), 32'd1);
        check("basic_data",  32'(rsp_data),  32'h1234);
        tick();
        check("basic_cleared",   32'(rsp_valid), 32'd0);
        check("basic_data_kept", 32'(rsp_data),  32'h1234);

        // write-first forwarding
        write_en = 1'b1; write_addr = 3'd3; write_data = 16'hA5A5;
        req_valid = 1'b1; req_addr = 3'd3;
        tick();
        write_en = 1'b0; req_valid = 1'b0;
        check("fwd_valid", 32'(rsp_valid), 32'd1);
        check("fwd_data",  32'(rsp_data),  32'hA5A5);
        tick();

        // backpressure with writes to the held address and a waiting request
        wr(3'd1, 16'h1111);
        wr(3'd6, 16'h0007);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 3'd6;
        tick();
        req_addr = 3'd1;
        write_en = 1'b1; write_addr = 3'd6; write_data = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_valid",     32'(rsp_valid), 32'd1);
            check("hold_data",      32'(rsp_data),  32'h0007);
            tick();
        end
        write_en  = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("release_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_valid", 32'(rsp_valid), 32'd1);
        check("b2b_data",  32'(rsp_data),  32'h1111);
        tick();
        check("b2b_cleared", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1; req_addr = 3'd6;
        tick();
        req_valid = 1'b0;
        check("held_addr_written", 32'(rsp_data), 32'hFFFF);
        tick();

        // streaming: preload addr*0101, read 0..7 back-to-back
        for (int a = 0; a < 8; a++) wr(3'(a), 16'(a * 16'h0101));
        req_valid = 1'b1;
        for (int a = 0; a < 8; a++) begin
            req_addr = 3'(a);
            tick();
            check("stream_valid", 32'(rsp_valid), 32'd1);
            check("stream_data",  32'(rsp_data),  32'(a * 16'h0101));
        end
        req_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(rsp_valid), 32'd0);
        check("stream_end_data",  32'(rsp_data),  32'h0707);

        // reset pulse between edges while a response is held
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 3'd4;
        tick();
        req_valid = 1'b0;
        check("midhold_valid", 32'(rsp_valid), 32'd1);
        check("midhold_data",  32'(rsp_data),  32'h0404);
        #2 reset_n = 1'b0;
        #1;
        check("midhold_reset_valid", 32'(rsp_valid), 32'd0);
        check("midhold_reset_data",  32'(rsp_data),  32'h0000);
        #1 reset_n = 1'b1;
        tick();
        tick();
        check("midhold_no_response", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 3'd4;
        tick();
        req_valid = 1'b0;
        check("midhold_mem_cleared", 32'(rsp_data), 32'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram8_port.md
RAM8_PORT -- requirements
Module: ram8_port

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of words; fixed at 8 (ADDR_W = 3).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port write_en  input  1  write strobe, sampled at rising edge.
REQ-006 SHALL have port write_addr  input  3  write word index.
REQ-007 SHALL have port write_data  input  WIDTH  write data.
REQ-008 SHALL have port req_valid  input  1  read request present.
REQ-009 SHALL have port req_addr  input  3  read word index, valid with req_valid.
REQ-010 SHALL have port req_ready  output  1  block can accept a read request this cycle.
REQ-011 SHALL have port rsp_valid  output  1  read response present.
REQ-012 SHALL have port rsp_data  output  WIDTH  read response data, valid with rsp_valid.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the response this cycle.

Function
REQ-014 SHALL store DEPTH words of WIDTH bits in edge-triggered registers; no latches, no combinational read path to rsp_data.
REQ-015 SHALL write write_data into word write_addr on each rising edge with write_en=1; other words unchanged.
REQ-016 SHALL drive req_ready = !rsp_valid || rsp_ready (combinational; one-entry response stage).
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; exactly one response per accepted request, in order.
REQ-018 SHALL present the response with 1-cycle latency: rsp_valid=1 and rsp_data=mem[req_addr] from the edge following acceptance.
REQ-019 SHALL, on accept with write_en=1 and write_addr=req_addr at the same edge, return write_data (write-first forwarding).
REQ-020 SHALL hold rsp_valid and rsp_data stable while rsp_valid=1 and rsp_ready=0, including across writes to the responded address.
REQ-021 SHALL clear rsp_valid at an edge with rsp_ready=1 and no new accept; accept with rsp_ready=1 replaces the response back-to-back (full throughput, one response per cycle).
REQ-022 SHALL ignore req_addr and req_valid while req_ready=0 (request not consumed; requester holds it).
REQ-023 SHALL never block writes; write_en is honoured every cycle regardless of read-side state.
REQ-024 SHALL keep rsp_data at its last value when rsp_valid=0 (no X, no toggling).

Reset
REQ-025 SHALL, while reset_n=0, immediately force all memory words to 0, rsp_valid=0, rsp_data=0; req_ready therefore 1.
REQ-026 SHALL discard any pending response and any same-cycle request or write when reset asserts mid-operation.
REQ-027 SHALL resume normal operation at the first rising edge after reset_n returns to 1.

Structure
REQ-028 SHALL place WIDTH default, DEPTH, and ADDR_W in shared package ram8_pkg.
REQ-029 SHALL instantiate one sub-module word_reg (WIDTH-bit register with load enable, async active-low reset) per memory word, 8 instances.
REQ-030 SHALL keep response stage (rsp_valid, rsp_data) and forwarding mux in ram8_port top level.

Verification
REQ-031 SHALL cover reset: assert reset_n=0 after writing 16'hBEEF to addr 2 -> rsp_valid=0 immediately; later read of addr 2 returns 16'h0000.
REQ-032 SHALL cover basic read: write 16'h1234 to addr 5, then request addr 5 with rsp_ready=1 -> rsp_valid=1 next cycle with rsp_data=16'h1234, cleared the cycle after.
REQ-033 SHALL cover forwarding: same edge write 16'hA5A5 to addr 3 and request addr 3 -> response 16'hA5A5.
REQ-034 SHALL cover backpressure: response 16'h0007 held with rsp_ready=0 for 4 cycles while writing 16'hFFFF to same addr -> rsp_data stays 16'h0007, req_ready=0 throughout.
REQ-035 SHALL cover streaming: requests addrs 0..7 on consecutive cycles, rsp_ready=1, memory preloaded with addr*16'h0101 -> 8 responses on consecutive cycles in order, values 16'h0000..16'h0707.
REQ-036 SHALL cover reset mid-hold: rsp_valid=1 with rsp_ready=0, pulse reset_n low between edges -> rsp_valid=0 and rsp_data=0 asynchronously, no response delivered after release.
